// File: rtl/pipelined_ripple_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_ripple_addsub
//
// N-bit add/subtract unit with the carry chain cut into STAGES segments of
// SEG = N/STAGES bits. Each pipeline stage ripples one segment and hands its
// carry to the next stage through a register. Upper operand segments are
// carried forward (skewed) until their stage is reached. Lower result
// segments are carried forward (de-skewed) so the whole Sum leaves together.
//
// Flow control is a single global advance:
//   advance = !out_valid || out_ready
// On advance every stage shifts one step and stage 0 takes the new beat, or a
// bubble when in_valid is low. Without advance the whole pipe holds.
//
// Parameters:
//   N       operand/result width, >= 2
//   STAGES  pipeline depth, 1..N, must divide N
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (drops every beat in flight)
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when in_valid && in_ready
//   A, B       operands (unsigned or two's complement)
//   Cin        carry-in, ignored when Sub=1
//   Sub        0: A + B + Cin, 1: A + ~B + 1
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   Sum        result, modulo 2^N
//   Cout       carry out of the MSB (for Sub=1, 1 means no borrow)
//   Ovf        signed overflow, only with PIPELINED_RIPPLE_ADDSUB_OVF_EN
//
// Optional feature macro: PIPELINED_RIPPLE_ADDSUB_OVF_EN
//   When defined, adds the Ovf output: carry into the MSB XOR Cout, registered
//   alongside Sum, reset to 0. When undefined the port and logic are absent.
// -----------------------------------------------------------------------------
module pipelined_ripple_addsub #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout
`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
  ,
  output logic         Ovf
`endif
);

  // Guarded so an illegal STAGES reaches the parameter check below instead of
  // faulting on a division by zero first.
  localparam int SEG = (STAGES > 0) ? (N / STAGES) : 1;
  localparam int REM = (STAGES > 0) ? (N % STAGES) : 1;

  if (N < 2 || STAGES < 1 || STAGES > N || REM != 0) begin : g_bad_params
    $fatal(1, "pipelined_ripple_addsub: illegal parameters N=%0d STAGES=%0d", N, STAGES);
  end

  // ---------------------------------------------------------------------------
  // Inter-stage links. Index k is what stage k consumes; index k+1 is what
  // stage k produces. Entry 0 is driven from the input ports.
  // ---------------------------------------------------------------------------
  logic         v_pipe [STAGES+1];  // stage valid bits
  logic         c_pipe [STAGES+1];  // segment carry
  logic [N-1:0] s_pipe [STAGES+1];  // partial result, low segments filled in
  logic [N-1:0] a_pipe [STAGES];    // operand A, skewed forward
  logic [N-1:0] b_pipe [STAGES];    // effective operand B (inverted for Sub)

  logic advance;

  assign advance  = !v_pipe[STAGES] || out_ready;
  assign in_ready = advance;

  assign v_pipe[0] = in_valid;
  assign a_pipe[0] = A;
  // Subtraction is A + ~B + 1: invert B and force the carry-in to 1, which
  // for a single bit is simply Sub | Cin.
  assign b_pipe[0] = Sub ? ~B : B;
  assign c_pipe[0] = Sub | Cin;
  assign s_pipe[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]   seg_res;
    logic [N-1:0]   s_next;
    logic           v_r;
    logic           c_r;
    logic [N-1:0]   s_r;

    // Ripple add of this stage's segment; bit SEG is the carry out.
    assign seg_res = {1'b0, a_pipe[k][k*SEG +: SEG]}
                   + {1'b0, b_pipe[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_pipe[k]};

    // NOTE: s_next takes a full default before the partial overwrite, so no
    // path through this block leaves a bit unassigned and no latch is inferred.
    always_comb begin
      s_next = s_pipe[k];
      s_next[k*SEG +: SEG] = seg_res[SEG-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift is race-free.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
      end else if (advance) begin
        v_r <= v_pipe[k];
      end
    end

    // NOTE: the data registers are reset as well; the last stage drives Sum and
    // Cout directly and those must read 0 during reset. Bubbles leave the data
    // untouched, so no X can flow in from an idle input bus.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_r <= '0;
        c_r <= 1'b0;
      end else if (advance && v_pipe[k]) begin
        s_r <= s_next;
        c_r <= seg_res[SEG];
      end
    end

    assign v_pipe[k+1] = v_r;
    assign c_pipe[k+1] = c_r;
    assign s_pipe[k+1] = s_r;

    // Operands only need to travel on while a later stage still consumes them.
    if (k < STAGES - 1) begin : g_skew
      logic [N-1:0] a_r;
      logic [N-1:0] b_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance && v_pipe[k]) begin
          a_r <= a_pipe[k];
          b_r <= b_pipe[k];
        end
      end

      assign a_pipe[k+1] = a_r;
      assign b_pipe[k+1] = b_r;
    end

`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
    // The carry into the MSB is recovered from the MSB sum bit and its two
    // operand bits; XOR with the carry out gives signed overflow.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (advance && v_pipe[k]) begin
          ovf_r <= a_pipe[k][N-1] ^ b_pipe[k][N-1] ^ s_next[N-1] ^ seg_res[SEG];
        end
      end

      assign Ovf = ovf_r;
    end
`endif
  end

  assign out_valid = v_pipe[STAGES];
  assign Sum       = s_pipe[STAGES];
  assign Cout      = c_pipe[STAGES];

endmodule

// File: tb/tb_pipelined_ripple_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_ripple_addsub
//
// Four instances (N=8, STAGES = 1, 2, 4, 8) share one operand stream. A beat
// is only offered when every instance is ready, so all four accept identical
// beats and must produce the same ordered result stream. Expected results are
// pushed to a scoreboard queue on acceptance; each instance keeps its own read
// index into it. Directed steps cover basic add, carry across the stage
// boundary, subtract, backpressure and mid-flight reset on the STAGES=2
// instance; random phases then sweep all four.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipelined_ripple_addsub;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;

  logic       in_ready_w  [NI];
  logic       out_valid_w [NI];
  logic [7:0] sum_w       [NI];
  logic       cout_w      [NI];
`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
  logic       ovf_w       [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipelined_ripple_addsub #(
      .N      (8),
      .STAGES (1 << g)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .A         (a),
      .B         (b),
      .Cin       (cin),
      .Sub       (sub),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .Sum       (sum_w[g]),
      .Cout      (cout_w[g])
`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
      ,
      .Ovf       (ovf_w[g])
`endif
    );
  end

  // Scoreboard: {ovf, cout, sum[7:0]} per accepted beat, plus acceptance cycle.
  logic [9:0] exp_q [$];
  int         acc_q [$];
  int         rd [NI];
  int         cyc;
  int         n_checks;
  int         n_fail;
  logic       exact_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 9-bit integer sum; overflow from operand/result signs.
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv, input logic sv);
    logic [7:0] be;
    logic [8:0] r;
    logic       ov;
    be = sv ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, be} + {8'd0, (sv ? 1'b1 : cv)};
    ov = (av[7] == be[7]) && (r[7] != av[7]);
`ifndef PIPELINED_RIPPLE_ADDSUB_OVF_EN
    ov = 1'b0;
`endif
    return {ov, r};
  endfunction

  function automatic logic [9:0] obs_of(input int i);
    logic [9:0] o;
    o = {1'b0, cout_w[i], sum_w[i]};
`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
    o[9] = ovf_w[i];
`endif
    return o;
  endfunction

  function automatic logic all_ready();
    logic r;
    r = 1'b1;
    for (int i = 0; i < NI; i++) r = r & in_ready_w[i];
    return r;
  endfunction

  // Called just after a rising edge: set out_ready, let in_ready settle, then
  // offer the beat only if every instance can take it.
  task automatic apply(input logic want, input logic ordy);
    out_ready = ordy;
    #1;
    in_valid = want && all_ready();
  endtask

  // One clock: sample handshakes on the falling edge, update the scoreboard,
  // then step past the next rising edge.
  task automatic cycle();
    int lat;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (out_valid_w[i] && out_ready) begin
        if (rd[i] < exp_q.size()) begin
          check($sformatf("sb_s%0d_beat%0d", 1 << i, rd[i]), 32'(obs_of(i)), 32'(exp_q[rd[i]]));
          lat = cyc - acc_q[rd[i]];
          if (exact_lat) check($sformatf("lat_s%0d", 1 << i), lat, 1 << i);
          else           check($sformatf("latmin_s%0d", 1 << i), 32'(lat >= (1 << i)), 1);
          rd[i]++;
        end else begin
          check($sformatf("spurious_s%0d", 1 << i), 32'(out_valid_w[i]), 0);
        end
      end
    end
    if (in_valid) begin
      exp_q.push_back(model(a, b, cin, sub));
      acc_q.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      apply(1'b0, 1'b1);
      cycle();
    end
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    logic took;
    took = 1'b0;
    a = av; b = bv; cin = cv; sub = sv;
    for (int k = 0; k < 50 && !took; k++) begin
      apply(1'b1, 1'b1);
      took = in_valid;
      cycle();
    end
    if (!took) check("send_timeout", 32'(took), 1);
  endtask

  // Bounded wait until the STAGES=2 instance shows a result (post-edge view).
  task automatic wait_out1(input string tag);
    int k;
    k = 0;
    while (!out_valid_w[1] && k < 20) begin
      apply(1'b0, 1'b1);
      cycle();
      k++;
    end
    check({tag, "_valid"}, 32'(out_valid_w[1]), 1);
  endtask

  task automatic random_phase(input int nbeats, input logic stall_mode);
    int   sent;
    int   guard;
    logic have;
    sent = 0; guard = 0; have = 1'b0;
    while (sent < nbeats && guard < 20000) begin
      if (!have) begin
        a    = 8'($urandom);
        b    = 8'($urandom);
        cin  = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      apply($urandom_range(0, 3) != 0, stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (in_valid) begin
        have = 1'b0;
        sent++;
      end
      cycle();
      guard++;
    end
    check("rand_sent", sent, nbeats);
  endtask

  task automatic check_drained(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s_count_s%0d", tag, 1 << i), rd[i], exp_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; exact_lat = 1'b1;
    for (int i = 0; i < NI; i++) rd[i] = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state.
    #12;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_valid_s%0d", 1 << i), 32'(out_valid_w[i]), 0);
      check($sformatf("rst_sum_s%0d", 1 << i), 32'(sum_w[i]), 0);
      check($sformatf("rst_cout_s%0d", 1 << i), 32'(cout_w[i]), 0);
`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
      check($sformatf("rst_ovf_s%0d", 1 << i), 32'(ovf_w[i]), 0);
`endif
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("rdy_after_rst_s%0d", 1 << i), 32'(in_ready_w[i]), 1);

    // T1: basic add, exact two-cycle latency on STAGES=2.
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    check("t1_not_yet", 32'(out_valid_w[1]), 0);
    apply(1'b0, 1'b1);
    cycle();
    check("t1_valid", 32'(out_valid_w[1]), 1);
    check("t1_sum", 32'(sum_w[1]), 'h10);
    check("t1_cout", 32'(cout_w[1]), 0);
    idle(10);

    // T2: carry ripples through both segments.
    send(8'hFF, 8'h00, 1'b1, 1'b0);
    wait_out1("t2");
    check("t2_sum", 32'(sum_w[1]), 'h00);
    check("t2_cout", 32'(cout_w[1]), 1);
    idle(10);

    // T3: back-to-back subtracts, then a signed-overflow subtract.
    send(8'h05, 8'h07, 1'b0, 1'b1);
    send(8'h81, 8'h01, 1'b1, 1'b1);
    check("t3a_valid", 32'(out_valid_w[1]), 1);
    check("t3a_sum", 32'(sum_w[1]), 'hFE);
    check("t3a_cout", 32'(cout_w[1]), 0);
    apply(1'b0, 1'b1);
    cycle();
    check("t3b_valid", 32'(out_valid_w[1]), 1);
    check("t3b_sum", 32'(sum_w[1]), 'h80);
    check("t3b_cout", 32'(cout_w[1]), 1);
    idle(10);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    wait_out1("t3c");
    check("t3c_sum", 32'(sum_w[1]), 'h7F);
    check("t3c_cout", 32'(cout_w[1]), 1);
`ifdef PIPELINED_RIPPLE_ADDSUB_OVF_EN
    check("t3c_ovf", 32'(ovf_w[1]), 1);
`endif
    idle(10);

    // T4: four beats with a three-cycle downstream stall mid-stream.
    exact_lat = 1'b0;
    send(8'h10, 8'h20, 1'b0, 1'b0);
    send(8'hF0, 8'h20, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      apply(1'b0, 1'b0);
      check("t4_in_ready", 32'(in_ready_w[1]), 0);
      check("t4_hold_valid", 32'(out_valid_w[1]), 1);
      check("t4_hold_data", 32'(obs_of(1)), 32'(exp_q[rd[1]]));
      cycle();
    end
    send(8'h33, 8'hCC, 1'b0, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    idle(12);
    check_drained("t4");
    exact_lat = 1'b1;

    // T5: asynchronous reset with two beats in flight.
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h44, 8'h33, 1'b1, 1'b0);
    check("t5_pre_valid", 32'(out_valid_w[1]), 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("t5_valid_s%0d", 1 << i), 32'(out_valid_w[i]), 0);
      check($sformatf("t5_sum_s%0d", 1 << i), 32'(sum_w[i]), 0);
      check($sformatf("t5_cout_s%0d", 1 << i), 32'(cout_w[i]), 0);
      rd[i] = exp_q.size();
    end
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h5A, 8'h25, 1'b0, 1'b0);
    wait_out1("t5_new");
    check("t5_new_sum", 32'(sum_w[1]), 'h7F);
    check("t5_new_cout", 32'(cout_w[1]), 0);
    idle(12);
    check_drained("t5");

    // T6: random sweep, first unstalled (exact latency), then with backpressure.
    random_phase(300, 1'b0);
    idle(12);
    check_drained("t6a");
    exact_lat = 1'b0;
    random_phase(1000, 1'b1);
    idle(12);
    check_drained("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_addsub.md
Name: pipelined_ripple_addsub

Overview:
- Parameterised N-bit add/subtract unit; carry ripples within segments of SEG = N/STAGES bits, one segment per pipeline stage.
- Successor to the team's combinational ripple carry adder: adds pipelining, a valid/ready handshake with backpressure, carry-in, and a subtract mode.
- Feeds datapath blocks that need wide adds at higher clock rates than a full N-bit carry chain allows.

Parameters:
- N, 8, operand and sum width in bits. Must be at least 2.
- STAGES, 2, pipeline stages. Must divide N exactly and lie in 1..N. A violation is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- A  input  N  operand A, unsigned or two's complement
- B  input  N  operand B
- Cin  input  1  carry-in; used only when Sub=0
- Sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- Sum  output  N  result
- Cout  output  1  carry-out of the MSB

Behaviour:
- Reset:
  - Asserting rst_n low clears every stage-valid bit immediately, independent of clk.
  - While reset is asserted: out_valid=0, Sum=0, Cout=0. in_ready=1 once rst_n is high.
  - All in-flight data is discarded. Data registers may also clear but this is not required, except Sum and Cout, which must read 0.
- Arithmetic:
  - Sub=0: {Cout,Sum} = A + B + Cin.
  - Sub=1: {Cout,Sum} = A + ~B + 1 (Cin ignored). Cout=1 means no borrow (A >= B unsigned).
  - All arithmetic is modulo 2^N; wrap-around is not flagged except via Cout.
- Stage k (0..STAGES-1):
  - Adds operand bits [k*SEG +: SEG] using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Upper operand segments are skew-delayed so that they arrive at their stage in step.
  - Lower result segments are de-skew-delayed so that all of Sum is presented together.
- Latency: exactly STAGES cycles from accepted input to out_valid, given no stall. STAGES=1 gives a single registered ripple adder.
- Throughput: one beat per cycle when out_ready is held high.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - An input beat is accepted when in_valid && in_ready.
  - On advance, every stage shifts forward one step. Stage 0 loads the new beat, or a bubble if in_valid=0.
  - When advance=0 the whole pipeline holds. Sum, Cout and out_valid stay stable while out_valid && !out_ready.
  - in_valid=1 with in_ready=0 is legal. The beat is not taken, and the source must hold it.
- Simultaneous events:
  - Output accept and input accept in the same cycle: both take place and no beat is lost.
  - rst_n falling while stalled: all beats are discarded, out_valid=0 immediately.
- Bubbles propagate as invalid stages. No bubble collapsing is required.
- No X may appear on Sum or Cout while out_valid=1.

Optional Feature:
- Macro: PIPELINED_RIPPLE_ADDSUB_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit): two's-complement signed overflow, computed as the carry into the MSB XOR Cout.
  - Ovf is registered and aligned with Sum. Reset value is 0.
- Undefined: the Ovf port does not exist and no overflow logic is generated.

Test Plan:
- All tests use N=8, STAGES=2 and out_ready=1 unless stated otherwise.
- T1 add: A=0x0F, B=0x01, Cin=0, Sub=0. Expect Sum=0x10, Cout=0, out_valid exactly 2 cycles after acceptance.
- T2 full carry ripple across the stage boundary: A=0xFF, B=0x00, Cin=1. Expect Sum=0x00, Cout=1.
- T3 subtract: first A=0x05, B=0x07, Sub=1, expecting Sum=0xFE and Cout=0. Back-to-back in the next cycle, A=0x81, B=0x01, Sub=1, expecting Sum=0x80 and Cout=1. With OVF_EN, 0x80-0x01 gives Sum=0x7F and Ovf=1.
- T4 backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream.
  - in_ready must drop and Sum/Cout must stay stable while stalled.
  - All 4 results must arrive in order with none dropped or duplicated.
  - Check against a reference model.
- T5 reset mid-flight: pull rst_n low asynchronously with 2 beats in flight. Expect out_valid=0, Sum=0 and Cout=0 immediately. After release, the first new beat's result is correct and no stale beat appears.
- T6 sweep: STAGES in {1, 2, 4, 8} with 1000 random operands each, mixing Sub and Cin, with random in_valid/out_ready. Expect every output to match the reference model, with latency equal to STAGES when unstalled.
